// File: rtl/mdu_seq_if.sv
// EX-stage handshake and result bus between the pipeline and the multiply/divide sequencer.
interface mdu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, op, a, b,
    input  busy, stall_req, done, div_by_zero, result_hi, result_lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, stall_req, done, div_by_zero, result_hi, result_lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) sequencer, one bit per cycle.
//   state   | meaning
//   IDLE    | waiting for start; stall_req follows start
//   RUN     | WIDTH iterations on operand magnitudes, stall_req high
//   DONE    | one cycle, done pulse, results just updated, stall released
module mdu_seq #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  mdu_seq_if.slave    s
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op;
  logic               r_sa;
  logic               r_neg;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_abs_a = s.a[WIDTH-1] ? -s.a : s.a;
  assign w_abs_b = s.b[WIDTH-1] ? -s.b : s.b;

  // MUL: acc = {partial, multiplier}; add multiplicand on lsb, then shift right with carry
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // DIV: acc = {remainder, dividend/quotient}; the W-bit subtract is exact whenever w_ge holds
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opnd});
  assign w_rem_sub  = w_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next = w_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg ? -w_mul_next : w_mul_next;
  assign w_quot     = r_neg ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
  assign w_rem      = r_sa  ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_op) begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_sa    <= 1'b0;
      r_neg   <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s.start) begin
            r_op  <= s.op;
            r_sa  <= s.a[WIDTH-1];
            r_neg <= s.a[WIDTH-1] ^ s.b[WIDTH-1];
            r_dbz <= 1'b0;
            if (s.op && (s.b == '0)) begin
              r_hi    <= s.a;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_opnd  <= s.op ? w_abs_b : w_abs_a;
              r_acc   <= {{WIDTH{1'b0}}, (s.op ? w_abs_a : w_abs_b)};
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_acc <= r_op ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s.busy        = r_busy;
  assign s.done        = r_done;
  assign s.div_by_zero = r_dbz;
  assign s.result_hi   = r_hi;
  assign s.result_lo   = r_lo;
  assign s.stall_req   = (s.start && (r_state == ST_IDLE)) || (r_state == ST_RUN);
endmodule

// File: tb/tb_mdu_seq.sv
// Directed and randomised checks of mdu_seq with an expected-result scoreboard.
module tb_mdu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  mdu_seq_if #(.WIDTH(W)) bus ();
  mdu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    m  = '0;
    if (op && (b == '0)) begin
      m.hi = a; m.lo = {W{1'b1}}; m.dbz = 1'b1;
    end else if (!op) begin
      p = sa * sb;
      m.hi = p[2*W-1:W]; m.lo = p[W-1:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      m.hi = r[W-1:0]; m.lo = q[W-1:0];
    end
    return m;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz, input int lat);
    exp_t e, exp_e;
    int cyc;
    exp_e.hi = ehi; exp_e.lo = elo; exp_e.dbz = edbz;
    sb_q.push_back(exp_e);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    chk({tag, "_stall_c0"}, {31'b0, bus.stall_req}, 1);
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.a = W'($urandom); bus.b = W'($urandom);
    cyc = 1;
    while ((bus.done !== 1'b1) && (cyc < 40)) begin
      chk({tag, "_stall_run"}, {31'b0, bus.stall_req}, 1);
      chk({tag, "_busy_run"}, {31'b0, bus.busy}, 1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_done_seen"}, {31'b0, bus.done}, 1);
    chk({tag, "_stall_done"}, {31'b0, bus.stall_req}, 0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, {16'b0, bus.result_hi}, {16'b0, e.hi});
      chk({tag, "_lo"}, {16'b0, bus.result_lo}, {16'b0, e.lo});
      chk({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
    end
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'b0, bus.done}, 0);
    chk({tag, "_hold"}, {bus.result_hi, bus.result_lo}, {ehi, elo});
  endtask

  initial begin
    exp_t m;
    int n0;
    logic [W-1:0] ra, rb;
    rst = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 0);
    chk("rst_result", {bus.result_hi, bus.result_lo}, 0);
    chk("rst_stall", {31'b0, bus.stall_req}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mul_3_m5",      1'b0, 16'h0003, 16'hFFFB, 16'hFFFF, 16'hFFF1, 1'b0, 17);
    do_op("mul_min_min",   1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 17);
    do_op("mul_max_m1",    1'b0, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8001, 1'b0, 17);
    do_op("div_100_7",     1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17);
    do_op("div_m7_2",      1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 17);
    do_op("div_7_m2",      1'b1, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 17);
    do_op("div_by_zero",   1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1);
    do_op("mul_2_2",       1'b0, 16'h0002, 16'h0002, 16'h0000, 16'h0004, 1'b0, 17);
    do_op("div_min_m1",    1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17);

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (rb == '0) rb = 16'h0005;
      m = model(1'(i % 2), ra, rb);
      do_op("rand", 1'(i % 2), ra, rb, m.hi, m.lo, m.dbz, 17);
    end

    // start pulses inside RUN and in the DONE cycle must not launch another op
    n0 = n_done;
    sb_q.push_back('{hi: 16'h0000, lo: 16'd30, dbz: 1'b0});
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd5; bus.b = 16'd6;
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      bus.start = ((c % 3) == 0);
      @(negedge clk);
    end
    bus.start = 1'b1;
    #1;
    chk("ign_done_seen", {31'b0, bus.done}, 1);
    chk("ign_stall_done", {31'b0, bus.stall_req}, 0);
    if (sb_q.size() > 0) begin
      m = sb_q.pop_front();
      chk("ign_result", {bus.result_hi, bus.result_lo}, {m.hi, m.lo});
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("ign_idle_after", {31'b0, bus.busy}, 0);
    repeat (20) @(negedge clk);
    chk("ign_one_done", n_done - n0, 1);
    chk("ign_still_idle", {31'b0, bus.busy}, 0);

    // reset in the middle of RUN aborts the op
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0010;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_mid_busy_before", {31'b0, bus.busy}, 1);
    n0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, bus.busy}, 0);
    chk("rst_mid_done", {31'b0, bus.done}, 0);
    chk("rst_mid_result", {bus.result_hi, bus.result_lo}, 0);
    chk("rst_mid_stall", {31'b0, bus.stall_req}, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("rst_mid_no_done", n_done - n0, 0);

    do_op("mul_after_rst", 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
